calc_rr_arbiter: RTL and testbench
==================================

// Module: calc_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one calculator (start/a/b/fct -> s/signal) among NREQ requesters.
//  Grants one request at a time, latches its operands, drives the calculator start handshake until done,
//  then returns the 2*WIDTH-bit result to the granted requester. Sits between client logic and the calculator.
// PARAMETERS
//  WIDTH    8   operand width; result is 2*WIDTH
//  NREQ     4   number of requesters (2..8)
//  TIMEOUT  64  max BUSY cycles before abort (used only with CALC_ARB_TIMEOUT_EN)
// PORTS
//  clock_i      in   1            single clock, rising edge
//  reset_i      in   1            synchronous, active-high reset
//  req_i        in   NREQ         request per requester; hold with operands until ack_o
//  a_i          in   NREQ*WIDTH   operand A, requester k at [k*WIDTH +: WIDTH]
//  b_i          in   NREQ*WIDTH   operand B, same packing
//  fct_i        in   NREQ*2       function code (00 add, 01 sub, 10 mul, 11 cmp), [k*2 +: 2]
//  ack_o        out  NREQ         one-hot, 1-cycle pulse: request k accepted
//  rsp_valid_o  out  NREQ         one-hot, 1-cycle pulse: result for requester k on s_o
//  s_o          out  2*WIDTH      result, valid only while a rsp_valid_o bit is high
//  err_o        out  1            with rsp_valid_o: 1 = aborted by timeout
//  calc_start_o out  1            calculator start (level)
//  calc_a_o     out  WIDTH        latched operand A to calculator
//  calc_b_o     out  WIDTH        latched operand B
//  calc_fct_o   out  2            latched function code
//  calc_s_i     in   2*WIDTH      calculator result
//  calc_done_i  in   1            calculator completion (its signal output)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, rr pointer 0, ack_o/rsp_valid_o/err_o/calc_start_o = 0,
//    s_o/calc_a_o/calc_b_o/calc_fct_o = 0, timeout counter 0. Reset mid-operation aborts silently (no rsp).
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if req_i != 0, grant g = first set bit searching ptr, ptr+1, ... mod NREQ. At the edge: latch
//    a/b/fct of g into calc_*_o, ack_o[g]=1, calc_start_o=1, ptr <= (g+1) mod NREQ, go BUSY. Else stay.
//  - BUSY: calc_start_o held 1, ack_o=0. calc_done_i ignored in first BUSY cycle (stale-done guard);
//    from second cycle on, done=1 at an edge -> s_o <= calc_s_i, rsp_valid_o[g]=1, err_o=0,
//    calc_start_o <= 0, go RESP.
//  - RESP: rsp_valid_o/s_o present exactly one cycle; at edge clear rsp_valid_o, go IDLE.
//  - Latency: req sampled in IDLE at cycle n -> ack_o at n+1; done sampled at cycle m -> rsp at m+1;
//    next arbitration sampled at m+2. Min request-to-response 3 cycles.
//  - req_i still high when IDLE re-entered is a new request (requester must drop req after ack_o).
//  - req_i changes during BUSY/RESP do not affect the current transaction (operands latched).
//  - calc_done_i in IDLE/RESP is ignored. Only one transaction outstanding; s_o held at last value
//    outside RESP is not guaranteed meaningful.
//  - Fairness: a continuously requesting client waits at most NREQ-1 transactions.
// CONFIGURATION
//  CALC_ARB_TIMEOUT_EN defined: BUSY cycle counter (clog2(TIMEOUT+1) bits) cleared on BUSY entry;
//    if it reaches TIMEOUT with no qualifying done -> rsp_valid_o[g]=1, err_o=1, s_o=0, calc_start_o=0, RESP.
//    Done and timeout on the same edge: done wins (err_o=0, real result).
//  Not defined: no counter; BUSY waits indefinitely; err_o tied 0; TIMEOUT ignored.
// TESTING  (WIDTH=8, NREQ=4, TIMEOUT=64; calculator model with 2-cycle done)
//  1. req0: a=AA b=55 fct=00 -> ack_o=0001 next cycle; rsp_valid_o=0001, s_o=00FF, err_o=0.
//  2. req2: a=05 b=C8 fct=10 -> calc_a_o=05 calc_b_o=C8 calc_fct_o=10; s_o=03E8 on rsp_valid_o=0100.
//  3. req_i=1111 held, ptr=0 -> grant order 0,1,2,3,0; each ack one-hot; no requester served twice
//     before the others.
//  4. reset_i=1 for 1 cycle mid-BUSY -> next cycle all outputs 0, no rsp_valid_o, ptr=0, new req0 served.
//  5. Model holds done=1 from previous op into next BUSY first cycle -> ignored; result taken from real done.
//  6. CALC_ARB_TIMEOUT_EN, model never asserts done -> after 64 BUSY cycles rsp_valid_o[g]=1, err_o=1,
//     s_o=0000; without macro: still BUSY after 1000 cycles, calc_start_o=1.

Source files
------------

// File: rtl/calc_rr_arbiter.sv
// calc_rr_arbiter: round-robin sequencer sharing one calculator among NREQ requesters.
// One transaction at a time: grant, latch operands, hold calc start until done, return result.
// Optional feature macro: CALC_ARB_TIMEOUT_EN (abort a BUSY transaction after TIMEOUT cycles).

module calc_rr_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] a_i,
  input  logic [NREQ*WIDTH-1:0] b_i,
  input  logic [NREQ*2-1:0]     fct_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [2*WIDTH-1:0]    s_o,
  output logic                  err_o,
  output logic                  calc_start_o,
  output logic [WIDTH-1:0]      calc_a_o,
  output logic [WIDTH-1:0]      calc_b_o,
  output logic [1:0]            calc_fct_o,
  input  logic [2*WIDTH-1:0]    calc_s_i,
  input  logic                  calc_done_i
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("calc_rr_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("calc_rr_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic             first_busy;

  logic [WIDTH-1:0] a_arr   [NREQ];
  logic [WIDTH-1:0] b_arr   [NREQ];
  logic [1:0]       fct_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k]   = a_i[k*WIDTH +: WIDTH];
    assign b_arr[k]   = b_i[k*WIDTH +: WIDTH];
    assign fct_arr[k] = fct_i[k*2 +: 2];
  end

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] sel_next;
  int unsigned   cand;
  logic [PW-1:0] cand_idx;

  // Rotating priority search: first set request at ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PW'(cand);
      if (!sel_found && req_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
    sel_next = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] busy_cnt;
  logic [CW-1:0] busy_cnt_next;
  logic          timeout_hit;

  // Counter value after the current BUSY cycle; hitting TIMEOUT aborts.
  always_comb begin
    busy_cnt_next = busy_cnt + 1'b1;
    timeout_hit   = (busy_cnt_next == CW'(TIMEOUT));
  end
`else
  assign err_o = 1'b0;
`endif

  // Arbitration / handshake sequencer with all outputs registered.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      grant_idx    <= '0;
      first_busy   <= 1'b0;
      ack_o        <= '0;
      rsp_valid_o  <= '0;
      s_o          <= '0;
      calc_start_o <= 1'b0;
      calc_a_o     <= '0;
      calc_b_o     <= '0;
      calc_fct_o   <= '0;
`ifdef CALC_ARB_TIMEOUT_EN
      err_o        <= 1'b0;
      busy_cnt     <= '0;
`endif
    end else begin
      ack_o       <= '0;
      rsp_valid_o <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            calc_a_o     <= a_arr[sel_idx];
            calc_b_o     <= b_arr[sel_idx];
            calc_fct_o   <= fct_arr[sel_idx];
            ack_o        <= NREQ'(1) << sel_idx;
            calc_start_o <= 1'b1;
            grant_idx    <= sel_idx;
            ptr          <= sel_next;
            first_busy   <= 1'b1;
`ifdef CALC_ARB_TIMEOUT_EN
            busy_cnt     <= '0;
`endif
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          first_busy <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
          busy_cnt   <= busy_cnt_next;
`endif
          // A done still high from the previous operation shows up in the first BUSY cycle.
          if (!first_busy && calc_done_i) begin
            s_o          <= calc_s_i;
            rsp_valid_o  <= NREQ'(1) << grant_idx;
            calc_start_o <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
            err_o        <= 1'b0;
`endif
            state        <= ST_RESP;
          end
`ifdef CALC_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            s_o          <= '0;
            rsp_valid_o  <= NREQ'(1) << grant_idx;
            calc_start_o <= 1'b0;
            err_o        <= 1'b1;
            state        <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
`ifdef CALC_ARB_TIMEOUT_EN
          err_o <= 1'b0;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_rr_arbiter.sv
// tb_calc_rr_arbiter: directed scenarios plus randomized clients against a transaction-level model.
// Honours CALC_ARB_TIMEOUT_EN the same way as the design.

module tb_calc_rr_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [W-1:0]     cl_a [N];
  logic [W-1:0]     cl_b [N];
  logic [1:0]       cl_f [N];
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N*2-1:0]   fct_in;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign a_in[k*W +: W] = cl_a[k];
    assign b_in[k*W +: W] = cl_b[k];
    assign fct_in[k*2 +: 2] = cl_f[k];
  end

  logic [N-1:0]     ack_o;
  logic [N-1:0]     rsp_valid_o;
  logic [2*W-1:0]   s_o;
  logic             err_o;
  logic             calc_start_o;
  logic [W-1:0]     calc_a_o;
  logic [W-1:0]     calc_b_o;
  logic [1:0]       calc_fct_o;
  logic [2*W-1:0]   calc_s = '0;
  logic             calc_done = 1'b0;

  calc_rr_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .a_i(a_in), .b_i(b_in), .fct_i(fct_in),
    .ack_o(ack_o), .rsp_valid_o(rsp_valid_o), .s_o(s_o), .err_o(err_o),
    .calc_start_o(calc_start_o), .calc_a_o(calc_a_o), .calc_b_o(calc_b_o),
    .calc_fct_o(calc_fct_o), .calc_s_i(calc_s), .calc_done_i(calc_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Calculator stand-in: result after calc_delay cycles of start; first start cycle drives garbage/stale done.
  int calc_delay = 2;
  bit calc_never = 1'b0;
  int first_mode = 0;   // 0: done low, 1: stale done=1 with DEAD, 2: random
  bit noise      = 1'b0;
  bit rand_delay = 1'b0;
  int ccnt       = 0;

  function automatic logic [15:0] calc_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    case (f)
      2'b00:   return 16'(a) + 16'(b);
      2'b01:   return 16'(a) - 16'(b);
      2'b10:   return 16'(a) * 16'(b);
      default: return (a > b) ? 16'd1 : ((a == b) ? 16'd0 : 16'hFFFF);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (calc_start_o) begin
        ccnt++;
        if (ccnt == 1) begin
          if (rand_delay) calc_delay = $urandom_range(2, 5);
          case (first_mode)
            0: calc_done = 1'b0;
            1: begin calc_done = 1'b1; calc_s = 16'hDEAD; end
            default: begin calc_done = 1'($urandom_range(0, 1)); calc_s = 16'($urandom); end
          endcase
        end else if (!calc_never && ccnt >= calc_delay) begin
          calc_done = 1'b1;
          calc_s    = calc_fn(calc_a_o, calc_b_o, calc_fct_o);
        end else begin
          calc_done = 1'b0;
          calc_s    = 16'($urandom);
        end
      end else begin
        ccnt = 0;
        if (first_mode == 1) begin
          calc_done = 1'b1;
          calc_s    = 16'hDEAD;
        end else if (noise) begin
          calc_done = 1'($urandom_range(0, 1));
          calc_s    = 16'($urandom);
        end else begin
          calc_done = 1'b0;
        end
      end
    end
  end

  // Transaction-level reference: at each falling edge compare this cycle's outputs,
  // then predict the next cycle from the inputs the coming rising edge will sample.
  bit             m_valid = 1'b0;
  int             m_phase = 0;   // 0 waiting for request, 1 calculator running, 2 result showing
  int             m_ptr   = 0;
  int             m_g     = 0;
  int             m_bcyc  = 0;
  logic [N-1:0]   e_ack, e_rsp;
  logic           e_err, e_start;
  logic [2*W-1:0] e_s;
  logic [W-1:0]   e_a, e_b;
  logic [1:0]     e_fct;
  bit             e_s_chk;

  initial begin
    bit found;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("ack", 64'(ack_o), 64'(e_ack));
        check("rsp_valid", 64'(rsp_valid_o), 64'(e_rsp));
        check("err", 64'(err_o), 64'(e_err));
        check("calc_start", 64'(calc_start_o), 64'(e_start));
        check("calc_a", 64'(calc_a_o), 64'(e_a));
        check("calc_b", 64'(calc_b_o), 64'(e_b));
        check("calc_fct", 64'(calc_fct_o), 64'(e_fct));
        if (e_s_chk) check("s", 64'(s_o), 64'(e_s));
      end
      if (rst) begin
        m_valid = 1'b1; m_phase = 0; m_ptr = 0; m_bcyc = 0;
        e_ack = '0; e_rsp = '0; e_err = 1'b0; e_start = 1'b0;
        e_s = '0; e_a = '0; e_b = '0; e_fct = '0; e_s_chk = 1'b1;
      end else begin
        e_ack = '0; e_rsp = '0; e_s_chk = 1'b0;
        case (m_phase)
          0: begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
              if (!found && req[(m_ptr + i) % N]) begin
                found = 1'b1;
                m_g   = (m_ptr + i) % N;
              end
            end
            if (found) begin
              e_a = cl_a[m_g]; e_b = cl_b[m_g]; e_fct = cl_f[m_g];
              e_ack[m_g] = 1'b1;
              e_start = 1'b1;
              m_ptr   = (m_g + 1) % N;
              m_bcyc  = 0;
              m_phase = 1;
            end
          end
          1: begin
            m_bcyc++;
            if (m_bcyc >= 2 && calc_done) begin
              e_rsp[m_g] = 1'b1; e_s = calc_s; e_err = 1'b0; e_start = 1'b0;
              e_s_chk = 1'b1; m_phase = 2;
            end
`ifdef CALC_ARB_TIMEOUT_EN
            else if (m_bcyc >= TO) begin
              e_rsp[m_g] = 1'b1; e_s = '0; e_err = 1'b1; e_start = 1'b0;
              e_s_chk = 1'b1; m_phase = 2;
            end
`endif
          end
          default: begin
            e_err   = 1'b0;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic wait_ack(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (ack_o != '0) begin lat = i; break; end
    end
    if (lat < 0) expired("ack_wait");
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o != '0) begin lat = i; break; end
    end
    if (lat < 0) expired("rsp_wait");
  endtask

  task automatic set_client(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    cl_a[k] = a; cl_b[k] = b; cl_f[k] = f;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int tx_count;
    logic [N-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < N; k++) set_client(k, 8'h00, 8'h00, 2'b00);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: add on requester 0, minimum latency
    @(posedge clk); #1;
    set_client(0, 8'hAA, 8'h55, 2'b00);
    req = 4'b0001;
    wait_ack(20, lat);
    check("t1_ack_latency", 64'(lat), 64'd1);
    check("t1_ack", 64'(ack_o), 64'h1);
    req = '0;
    wait_rsp(20, lat);
    check("t1_rsp_latency", 64'(lat), 64'd2);
    check("t1_rsp", 64'(rsp_valid_o), 64'h1);
    check("t1_s", 64'(s_o), 64'h00FF);
    check("t1_err", 64'(err_o), 64'd0);

    // 2: multiply on requester 2, operand latch
    @(posedge clk); #1;
    set_client(2, 8'h05, 8'hC8, 2'b10);
    req = 4'b0100;
    wait_ack(20, lat);
    check("t2_ack", 64'(ack_o), 64'h4);
    check("t2_calc_a", 64'(calc_a_o), 64'h05);
    check("t2_calc_b", 64'(calc_b_o), 64'hC8);
    check("t2_calc_fct", 64'(calc_fct_o), 64'h2);
    req = '0;
    wait_rsp(20, lat);
    check("t2_rsp", 64'(rsp_valid_o), 64'h4);
    check("t2_s", 64'(s_o), 64'h03E8);

    // 3: all requesting from ptr=0 -> 0,1,2,3,0
    pulse_reset();
    for (int k = 0; k < N; k++) set_client(k, 8'(k + 1), 8'(k + 3), 2'b00);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(40, lat);
      check($sformatf("t3_grant%0d", j), 64'(ack_o), 64'(order[j]));
    end
    req = '0;
    wait_rsp(20, lat);

    // 4: reset in the middle of BUSY aborts silently, pointer back to 0
    @(posedge clk); #1;
    set_client(0, 8'h11, 8'h22, 2'b00);
    req = 4'b0001;
    wait_ack(20, lat);
    req = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("t4_ack", 64'(ack_o), 64'd0);
    check("t4_rsp", 64'(rsp_valid_o), 64'd0);
    check("t4_start", 64'(calc_start_o), 64'd0);
    check("t4_calc_a", 64'(calc_a_o), 64'd0);
    check("t4_s", 64'(s_o), 64'd0);
    check("t4_err", 64'(err_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o != '0) seen++;
    end
    check("t4_no_rsp_after_reset", 64'(seen), 64'd0);
    set_client(0, 8'h21, 8'h03, 2'b10);
    set_client(1, 8'h01, 8'h01, 2'b00);
    set_client(3, 8'h02, 8'h02, 2'b00);
    req = 4'b1011;
    wait_ack(20, lat);
    check("t4_regrant", 64'(ack_o), 64'h1);
    req = '0;
    wait_rsp(20, lat);
    check("t4_s", 64'(s_o), 64'h0063);

    // 5: done left high from before must not complete the first BUSY cycle
    first_mode = 1;
    calc_delay = 3;
    @(posedge clk); #1;
    set_client(1, 8'h12, 8'h34, 2'b01);
    req = 4'b0010;
    wait_ack(20, lat);
    check("t5_ack", 64'(ack_o), 64'h2);
    req = '0;
    wait_rsp(20, lat);
    check("t5_rsp_latency", 64'(lat), 64'd3);
    check("t5_rsp", 64'(rsp_valid_o), 64'h2);
    check("t5_s", 64'(s_o), 64'hFFDE);
    check("t5_err", 64'(err_o), 64'd0);
    first_mode = 0;
    calc_delay = 2;

    // 6: calculator never finishes
    calc_never = 1'b1;
    @(posedge clk); #1;
    set_client(3, 8'h77, 8'h88, 2'b11);
    req = 4'b1000;
    wait_ack(20, lat);
    req = '0;
`ifdef CALC_ARB_TIMEOUT_EN
    wait_rsp(200, lat);
    check("t6_timeout_latency", 64'(lat), 64'd64);
    check("t6_rsp", 64'(rsp_valid_o), 64'h8);
    check("t6_err", 64'(err_o), 64'd1);
    check("t6_s", 64'(s_o), 64'd0);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o != '0) seen++;
    end
    check("t6_no_rsp", 64'(seen), 64'd0);
    check("t6_start_held", 64'(calc_start_o), 64'd1);
`endif
    calc_never = 1'b0;
    pulse_reset();

    // Randomized clients: hold req with operands until ack, then drop and scramble operands.
    first_mode = 2;
    noise      = 1'b1;
    rand_delay = 1'b1;
    tx_count   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rsp_valid_o != '0) tx_count++;
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < N; k++) begin
        if (ack_o[k]) begin
          req[k] = 1'b0;
          set_client(k, 8'($urandom), 8'($urandom), 2'($urandom));
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          set_client(k, 8'($urandom), 8'($urandom), 2'($urandom));
          req[k] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (20) @(posedge clk);
    check("random_progress", 64'(tx_count >= 50), 64'd1);

    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
